// File: rtl/pst_stim_pkg.sv
// pst_stim_pkg: shared state, entry type and default thresholds for the stimulus sequencer
package pst_stim_pkg;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_CONV_TH = 5;
    localparam int unsigned DEF_HOLD    = 3;
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;
    typedef struct packed {
        logic [7:0]           cur;
        logic [DEF_CNT_W-1:0] len;
    } entry_t;
endpackage

// File: rtl/pst_conv_tracker.sv
// pst_conv_tracker: counts consecutive converged error samples and latches the first converged cycle
module pst_conv_tracker #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CONV_TH = 5,
    parameter int unsigned HOLD    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [CNT_W-1:0] k,
    input  logic [7:0]       err_in,
    input  logic             clr,
    output logic             conv_flag,
    output logic [CNT_W-1:0] conv_cycle
);
    logic [3:0]       run_q, run_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    // run length update and capture of the cycle where the converged run began
    always_comb begin
        run_d  = run_q;
        flag_d = flag_q;
        cyc_d  = cyc_q;
        if (clr) begin
            run_d  = '0;
            flag_d = 1'b0;
            cyc_d  = '0;
        end else if (sample_en) begin
            run_d = (err_in <= 8'(CONV_TH)) ? ((run_q == 4'(HOLD)) ? run_q : run_q + 4'd1) : 4'd0;
            if (run_d == 4'(HOLD) && !flag_q) begin
                flag_d = 1'b1;
                cyc_d  = k - CNT_W'(HOLD - 1);
            end
        end
    end
    // tracker state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            flag_q <= 1'b0;
            cyc_q  <= '0;
        end else begin
            run_q  <= run_d;
            flag_q <= flag_d;
            cyc_q  <= cyc_d;
        end
    end
    assign conv_flag  = flag_q;
    assign conv_cycle = cyc_q;
endmodule

// File: rtl/pst_stim_sequencer.sv
// pst_stim_sequencer: plays a programmed current schedule aligned to gamma cycle_start and reports convergence per segment
module pst_stim_sequencer
    import pst_stim_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CONV_TH = DEF_CONV_TH,
    parameter int unsigned HOLD    = DEF_HOLD,
    localparam int unsigned CNT_W  = DEF_CNT_W,
    localparam int unsigned IW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cycle_start,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [7:0]       wr_cur,
    input  logic [CNT_W-1:0] wr_len,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       err_in,
    output logic [7:0]       cur_out,
    output logic [IW-1:0]    seg_idx,
    output logic             busy,
    output logic             seg_start,
    output logic             seg_done,
    output logic             conv_flag,
    output logic [CNT_W-1:0] conv_cycle,
    output logic             done
);
    state_e           state_q, state_d;
    entry_t           tbl_q [DEPTH];
    logic [IW-1:0]    idx_q, idx_d, nxt;
    logic [CNT_W-1:0] k_q, k_d;
    logic [7:0]       cur_q, cur_d;
    logic             ss_q, ss_d, sd_q, sd_d, dn_q, dn_d, busy_q;
    logic             load, sample, last;
    // schedule FSM: arm on start, load on cycle_start, step segments at their final gamma cycle
    always_comb begin
        nxt     = idx_q + 1'b1;
        last    = (idx_q == IW'(DEPTH - 1)) || (tbl_q[nxt].len == '0);
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        cur_d   = cur_q;
        ss_d    = 1'b0;
        sd_d    = 1'b0;
        dn_d    = 1'b0;
        load    = 1'b0;
        sample  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cur_d   = '0;
        end else if (state_q == IDLE) begin
            if (start && tbl_q[0].len != '0) begin
                state_d = ARM;
                idx_d   = '0;
            end
        end else if (state_q == ARM) begin
            if (cycle_start) begin
                state_d = RUN;
                cur_d   = tbl_q[idx_q].cur;
                k_d     = CNT_W'(1);
                ss_d    = 1'b1;
                load    = 1'b1;
            end
        end else if (cycle_start) begin
            sample = k_q != CNT_W'(1);
            if (k_q == tbl_q[idx_q].len) begin
                sd_d = 1'b1;
                if (last) begin
                    state_d = IDLE;
                    cur_d   = '0;
                    dn_d    = 1'b1;
                end else begin
                    idx_d = nxt;
                    cur_d = tbl_q[nxt].cur;
                    k_d   = CNT_W'(1);
                    ss_d  = 1'b1;
                end
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end
    // FSM, counter, output and schedule table registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            cur_q   <= '0;
            ss_q    <= 1'b0;
            sd_q    <= 1'b0;
            dn_q    <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i].len <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            cur_q   <= cur_d;
            ss_q    <= ss_d;
            sd_q    <= sd_d;
            dn_q    <= dn_d;
            busy_q  <= state_d != IDLE;
            if (state_q == IDLE && wr_en && !abort) tbl_q[wr_addr] <= '{cur: wr_cur, len: wr_len};
        end
    end
    pst_conv_tracker #(
        .CNT_W  (CNT_W),
        .CONV_TH(CONV_TH),
        .HOLD   (HOLD)
    ) u_conv (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample),
        .k         (k_q),
        .err_in    (err_in),
        .clr       (abort | load | sd_q),
        .conv_flag (conv_flag),
        .conv_cycle(conv_cycle)
    );
    assign cur_out   = cur_q;
    assign seg_idx   = idx_q;
    assign busy      = busy_q;
    assign seg_start = ss_q;
    assign seg_done  = sd_q;
    assign done      = dn_q;
endmodule

// File: tb/tb_pst_stim_sequencer.sv
// tb_pst_stim_sequencer: randomized schedule runs checked against a window-based convergence model
module tb_pst_stim_sequencer;
    localparam int TH   = 5;
    localparam int HOLD = 3;
    logic        clk = 1'b0;
    logic        rst, cycle_start, wr_en, start, abort;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_cur, err_in;
    logic [15:0] wr_len;
    logic [7:0]  cur_out;
    logic [2:0]  seg_idx;
    logic        busy, seg_start, seg_done, conv_flag, done;
    logic [15:0] conv_cycle;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_cur [8];
    int          m_len [8];
    logic [7:0]  errs [8][16];
    logic        g_ss, g_sd, g_dn, g_cf, g_cf2, g_busy;
    logic [7:0]  g_cur;
    logic [2:0]  g_idx;
    logic [15:0] g_cc;

    always #5 clk = ~clk;

    pst_stim_sequencer dut (
        .clk(clk), .rst(rst), .cycle_start(cycle_start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_cur(wr_cur), .wr_len(wr_len), .start(start), .abort(abort), .err_in(err_in),
        .cur_out(cur_out), .seg_idx(seg_idx), .busy(busy), .seg_start(seg_start),
        .seg_done(seg_done), .conv_flag(conv_flag), .conv_cycle(conv_cycle), .done(done)
    );

    function automatic int nsegs();
        int n = 0;
        while (n < 8 && m_len[n] != 0) n++;
        return n;
    endfunction

    function automatic int exp_conv(int s);
        for (int c = 2; c + HOLD - 1 <= m_len[s]; c++) begin
            bit ok = 1'b1;
            for (int j = c; j < c + HOLD; j++) if (int'(errs[s][j]) > TH) ok = 1'b0;
            if (ok) return c;
        end
        return 0;
    endfunction

    task automatic write_entry(input int a, input int c, input int l);
        wr_en = 1'b1; wr_addr = 3'(a); wr_cur = 8'(c); wr_len = 16'(l);
        @(negedge clk);
        wr_en = 1'b0;
        m_cur[a] = 8'(c);
        m_len[a] = l;
    endtask

    task automatic rand_errs();
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < 16; k++)
                errs[s][k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
    endtask

    task automatic gamma(input logic [7:0] e);
        int extra = 0;
        cycle_start = 1'b1; err_in = e;
        @(negedge clk);
        cycle_start = 1'b0;
        g_ss = seg_start; g_sd = seg_done; g_dn = done; g_cf = conv_flag; g_cc = conv_cycle;
        g_cur = cur_out; g_idx = seg_idx; g_busy = busy;
        @(negedge clk);
        g_cf2 = conv_flag;
        repeat (14) begin
            @(negedge clk);
            extra += int'(seg_start | seg_done | done);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL stray_pulse: %0d pulses between cycle_starts, expected 0", extra);
        end
    endtask

    task automatic run_schedule(input bit meddle);
        int n = nsegs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", busy); end
        gamma(8'($urandom_range(0, 255)));
        checks++;
        if (g_ss !== 1'b1 || g_cur !== m_cur[0] || g_idx !== 3'd0 || g_sd !== 1'b0) begin
            errors++;
            $display("FAIL first_load: ss=%b cur=%0d idx=%0d sd=%b expected ss=1 cur=%0d idx=0 sd=0", g_ss, g_cur, g_idx, g_sd, m_cur[0]);
        end
        for (int s = 0; s < n; s++) begin
            for (int k = 1; k <= m_len[s]; k++) begin
                gamma(errs[s][k]);
                if (meddle && s == 0 && k == 1) begin
                    wr_en = 1'b1; wr_addr = 3'($urandom); wr_cur = 8'($urandom); wr_len = 16'($urandom); start = 1'b1;
                    @(negedge clk);
                    wr_en = 1'b0; start = 1'b0;
                    checks++;
                    if (busy !== 1'b1 || seg_start !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_meddle: busy=%b ss=%b expected busy=1 ss=0", busy, seg_start);
                    end
                end
                if (k < m_len[s]) begin
                    checks++;
                    if (g_sd !== 1'b0 || g_ss !== 1'b0 || g_dn !== 1'b0 || g_busy !== 1'b1 || g_cur !== m_cur[s]) begin
                        errors++;
                        $display("FAIL mid_segment s%0d k%0d: sd=%b ss=%b done=%b busy=%b cur=%0d expected 0 0 0 1 %0d", s, k, g_sd, g_ss, g_dn, g_busy, g_cur, m_cur[s]);
                    end
                end else begin
                    int ec = exp_conv(s);
                    bit lst = (s == n - 1);
                    checks++;
                    if (g_sd !== 1'b1 || g_cf !== (ec != 0) || g_cc !== 16'(ec) || g_cf2 !== 1'b0) begin
                        errors++;
                        $display("FAIL seg_done s%0d: sd=%b flag=%b cycle=%0d flag_after=%b expected 1 %b %0d 0", s, g_sd, g_cf, g_cc, g_cf2, ec != 0, ec);
                    end
                    checks++;
                    if (lst ? (g_dn !== 1'b1 || g_cur !== 8'd0 || g_busy !== 1'b0 || g_ss !== 1'b0)
                            : (g_dn !== 1'b0 || g_ss !== 1'b1 || g_cur !== m_cur[s+1] || g_idx !== 3'(s + 1) || g_busy !== 1'b1)) begin
                        errors++;
                        $display("FAIL seg_next s%0d last=%b: done=%b ss=%b cur=%0d idx=%0d busy=%b", s, lst, g_dn, g_ss, g_cur, g_idx, g_busy);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cycle_start = 1'b0; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
        wr_addr = '0; wr_cur = '0; wr_len = '0; err_in = '0;
        for (int i = 0; i < 8; i++) begin m_len[i] = 0; m_cur[i] = '0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (cur_out !== 8'd0 || seg_idx !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_main: cur=%0d idx=%0d busy=%b expected 0", cur_out, seg_idx, busy);
        end
        checks++;
        if (seg_start !== 1'b0 || seg_done !== 1'b0 || done !== 1'b0 || conv_flag !== 1'b0 || conv_cycle !== 16'd0) begin
            errors++; $display("FAIL reset_pulses: ss=%b sd=%b done=%b flag=%b cycle=%0d expected 0", seg_start, seg_done, done, conv_flag, conv_cycle);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_table: busy=%b expected 0 (len[0] cleared)", busy); end
    endtask

    task automatic test_single();
        write_entry(0, 50, 10);
        write_entry(1, 0, 0);
        for (int k = 0; k < 16; k++) errs[0][k] = (k <= 3) ? 8'd20 : 8'd2;
        run_schedule(1'b0);
    endtask

    task automatic test_two_seg();
        write_entry(0, 50, 6);
        write_entry(1, 10, 6);
        write_entry(2, 0, 0);
        for (int s = 0; s < 8; s++) for (int k = 0; k < 16; k++) errs[s][k] = 8'd8;
        run_schedule(1'b0);
    endtask

    task automatic test_alternate();
        logic [7:0] pat [8];
        pat = '{8'd9, 8'd9, 8'd3, 8'd3, 8'd9, 8'd3, 8'd3, 8'd3};
        write_entry(0, 77, 8);
        write_entry(1, 0, 0);
        for (int k = 0; k < 16; k++) errs[0][k] = (k < 8) ? pat[k] : 8'd9;
        run_schedule(1'b0);
    endtask

    task automatic test_full();
        for (int s = 0; s < 8; s++) write_entry(s, 30 + s, 2);
        rand_errs();
        run_schedule(1'b0);
    endtask

    task automatic test_random();
        repeat (6) begin
            int n = $urandom_range(1, 8);
            for (int s = 0; s < 8; s++) write_entry(s, $urandom_range(1, 255), (s < n) ? $urandom_range(1, 12) : 0);
            rand_errs();
            run_schedule(1'b0);
        end
    endtask

    task automatic test_abort();
        write_entry(0, 11, 4);
        write_entry(1, 22, 5);
        write_entry(2, 33, 3);
        write_entry(3, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) gamma(8'd0);
        checks++;
        if (g_idx !== 3'd1 || g_busy !== 1'b1) begin
            errors++; $display("FAIL abort_setup: idx=%0d busy=%b expected 1 1", g_idx, g_busy);
        end
        abort = 1'b1; cycle_start = 1'b1; err_in = 8'd0;
        @(negedge clk);
        abort = 1'b0; cycle_start = 1'b0;
        checks++;
        if (busy !== 1'b0 || cur_out !== 8'd0 || done !== 1'b0 || seg_done !== 1'b0 || seg_start !== 1'b0) begin
            errors++; $display("FAIL abort_next: busy=%b cur=%0d done=%b sd=%b ss=%b expected all 0", busy, cur_out, done, seg_done, seg_start);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b done=%b expected 0 0", busy, done);
        end
        rand_errs();
        run_schedule(1'b0);
    endtask

    task automatic test_ignore();
        write_entry(0, $urandom_range(1, 255), 6);
        write_entry(1, $urandom_range(1, 255), 3);
        write_entry(2, 0, 0);
        rand_errs();
        run_schedule(1'b1);
        run_schedule(1'b0);
        write_entry(0, 99, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_len0: busy=%b expected 0", busy); end
        gamma(8'd0);
        checks++;
        if (g_busy !== 1'b0 || g_ss !== 1'b0 || g_cur !== 8'd0) begin
            errors++; $display("FAIL start_len0_cs: busy=%b ss=%b cur=%0d expected 0 0 0", g_busy, g_ss, g_cur);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_seg();
        test_alternate();
        test_full();
        test_abort();
        test_ignore();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
